data_sram_axi_bridge: RTL and testbench
=======================================

# data_sram_axi_bridge

Data-side responder for the pipeline's sram-like memory port: accepts the M-stage load/store request (enable, write, byte select, address, write data), drives `d_stall` while the access is outstanding, and performs it as one single-beat AXI read or write transaction. Sits between the CPU core's data port and the SoC AXI interconnect. An instruction-side twin is a later block.

## Interface
- No parameters. AXI ID/len/burst/cache/prot/lock are tied to constants (ID = 1, len = 0, burst INCR) in the SoC wrapper and are not ports of this block.
- `clk`  in  1  sole clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `longest_stall`  in  1  global pipeline stall from the core; 0 means the M→W registers advance this cycle
- `data_en`  in  1  M-stage memory request valid
- `data_wen`  in  1  1 = store, 0 = load
- `data_sel`  in  4  store byte enables (legal: 0001/0010/0100/1000/0011/1100/1111)
- `data_addr`  in  32  byte address
- `data_wdata`  in  32  store data, already lane-aligned
- `data_rdata`  out  32  full read word, registered
- `d_stall`  out  1  request not yet complete
- `araddr` out 32, `arsize` out 3, `arvalid` out 1, `arready` in 1
- `rdata` in 32, `rvalid` in 1, `rready` out 1
- `awaddr` out 32, `awsize` out 3, `awvalid` out 1, `awready` in 1
- `wdata` out 32, `wstrb` out 4, `wvalid` out 1, `wready` in 1
- `bvalid` in 1, `bready` out 1

## Operation
- States: IDLE, RD_A, RD_D, WR_AW (AW and/or W pending), WR_B.
- IDLE: if `data_en & ~done_q` → capture addr/sel/wdata/wen; go RD_A (load) or WR_AW (store).
- RD_A: `arvalid`=1, `araddr`={addr[31:2],2'b00}, `arsize`=2; on `arready` → RD_D.
- RD_D: `rready`=1; on `rvalid` capture `rdata` into `rdata_q` → IDLE.
- WR_AW: `awvalid` and `wvalid` raised together, each dropped independently on its handshake; `awaddr`=addr, `wstrb`=sel, `wdata`=wdata, `awsize` = 0 for one-hot sel, 1 for 0011/1100, 2 for 1111. When both have handshaken (same or different cycles) → WR_B.
- WR_B: `bready`=1; on `bvalid` → IDLE. `bresp`/`rresp` are ignored.
- `done_q`: set on completion if `data_en` is high that cycle; cleared in any cycle with `longest_stall`=0. Prevents reissue while the core is frozen by `i_stall` or `div_stall`.
- `d_stall = (data_en & ~done_q) | (state != IDLE)`.
- Orphaned access: if `data_en` drops mid-transaction (exception flush), the AXI transaction still completes; `done_q` is not set and `d_stall` stays high until IDLE.
- `data_rdata = rdata_q`, unchanged by writes; the core selects bytes and lanes itself.

## Timing
- Reset values: state IDLE, `done_q`=0, `rdata_q`=0, all valid/ready outputs 0, all address/data/size/strb outputs 0; `d_stall` = `data_en`.
- Read with zero-wait slave: cycle 0 request seen (`d_stall`=1); cycle 1 `arvalid`; cycle 2 `rready`, `rvalid`; cycle 3 `d_stall`=0 and `data_rdata` valid. Three stall cycles minimum.
- Write with zero-wait slave: cycle 1 AW+W; cycle 2 B; cycle 3 `d_stall`=0.
- AXI valids are registered. Once asserted they hold, with stable payload, until handshake.
- Same cycle as completion with `longest_stall`=0: `done_q` is set, then cleared on the next qualifying edge. The next request is issued no earlier than one cycle after `done_q` clears.
- `rst` mid-transaction: immediate return to reset values. No drain; the whole SoC resets together.

## Structure
- Shared package `mips_axi_pkg`: state encoding, AXI constant ID (1), size codes (SZ_B=0, SZ_H=1, SZ_W=2), function `sel2size`.
- Single module, no sub-modules. `sel2size` is a package function, not an instance.

## Test plan
- Load 0x8000_0004, slave returns 0xDEAD_BEEF after 0-wait AR/R → `araddr`=0x8000_0004, `arsize`=2, `d_stall` high cycles 0–2, `data_rdata`=0xDEAD_BEEF at cycle 3.
- Store `sel`=1100, addr 0x8000_0012, `awready` 3 cycles after `wready` → `awaddr`=0x8000_0012, `awsize`=1, `wstrb`=1100, W dropped at its own handshake, single B, `d_stall` low the cycle after `bvalid`.
- Completed load while `longest_stall` held high 5 cycles → no second `arvalid`, `d_stall`=0 throughout, `data_rdata` stable.
- `data_en` dropped during RD_D → R still accepted, `done_q` stays 0; new store request issued only after return to IDLE.
- `rst` asserted in WR_AW with `awvalid`=1 → next cycle all valids 0, state IDLE, `rdata_q`=0.

Source files
------------

// File: rtl/mips_axi_pkg.sv
// Shared definitions for the sram-like to AXI bridges: state encoding, AXI constants
// and the byte-select to transfer-size mapping.
package mips_axi_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StRdA,
      StRdD,
      StWrAw,
      StWrB
   } axiState_e;

   localparam logic [3:0] AXI_ID = 4'd1;

   localparam logic [2:0] SZ_B = 3'd0;
   localparam logic [2:0] SZ_H = 3'd1;
   localparam logic [2:0] SZ_W = 3'd2;

   // Legal selects only: full word, aligned halfword, otherwise a single byte.
   function automatic logic [2:0] sel2size(input logic [3:0] sel);
      logic [2:0] size;
      case (sel)
         4'b1111:          size = SZ_W;
         4'b0011, 4'b1100: size = SZ_H;
         default:          size = SZ_B;
      endcase
      return size;
   endfunction

endpackage

// File: rtl/data_sram_axi_bridge.sv
// Data-side bridge: turns one M-stage load/store request into a single-beat AXI
// read or write and stalls the pipeline until it completes.
module data_sram_axi_bridge
   import mips_axi_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        longest_stall,
   input  logic        data_en,
   input  logic        data_wen,
   input  logic [3:0]  data_sel,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic [31:0] data_rdata,
   output logic        d_stall,
   output logic [31:0] araddr,
   output logic [2:0]  arsize,
   output logic        arvalid,
   input  logic        arready,
   input  logic [31:0] rdata,
   input  logic        rvalid,
   output logic        rready,
   output logic [31:0] awaddr,
   output logic [2:0]  awsize,
   output logic        awvalid,
   input  logic        awready,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wvalid,
   input  logic        wready,
   input  logic        bvalid,
   output logic        bready
);

   axiState_e   state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [3:0]  sel_q, sel_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        awDone_q, awDone_d;
   logic        wDone_q, wDone_d;
   logic        done_q, done_d;
   logic        complete;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         addr_q   <= '0;
         sel_q    <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         awDone_q <= 1'b0;
         wDone_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         sel_q    <= sel_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         awDone_q <= awDone_d;
         wDone_q  <= wDone_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      sel_d    = sel_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      awDone_d = awDone_q;
      wDone_d  = wDone_q;
      complete = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (data_en && !done_q) begin
               addr_d  = data_addr;
               sel_d   = data_sel;
               wdata_d = data_wdata;
               state_d = data_wen ? StWrAw : StRdA;
            end
         end
         StRdA: begin
            if (arready) state_d = StRdD;
         end
         StRdD: begin
            if (rvalid) begin
               rdata_d  = rdata;
               complete = 1'b1;
               state_d  = StIdle;
            end
         end
         StWrAw: begin
            // AW and W may handshake in either order; remember each one separately.
            awDone_d = awDone_q | (awvalid & awready);
            wDone_d  = wDone_q | (wvalid & wready);
            if (awDone_d && wDone_d) begin
               awDone_d = 1'b0;
               wDone_d  = 1'b0;
               state_d  = StWrB;
            end
         end
         StWrB: begin
            if (bvalid) begin
               complete = 1'b1;
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // Set wins over clear so a completion with the pipeline moving still blocks reissue.
      if (complete && data_en) begin
         done_d = 1'b1;
      end else if (!longest_stall) begin
         done_d = 1'b0;
      end else begin
         done_d = done_q;
      end
   end

   assign araddr  = {addr_q[31:2], 2'b00};
   assign arsize  = (state_q == StRdA) ? SZ_W : 3'd0;
   assign arvalid = (state_q == StRdA);
   assign rready  = (state_q == StRdD);

   assign awaddr  = addr_q;
   assign awsize  = sel2size(sel_q);
   assign awvalid = (state_q == StWrAw) && !awDone_q;
   assign wdata   = wdata_q;
   assign wstrb   = sel_q;
   assign wvalid  = (state_q == StWrAw) && !wDone_q;
   assign bready  = (state_q == StWrB);

   assign data_rdata = rdata_q;
   assign d_stall    = (data_en && !done_q) || (state_q != StIdle);

endmodule

// File: tb/tb_data_sram_axi_bridge.sv
// Directed bench for data_sram_axi_bridge: inputs change and outputs are sampled
// on the falling edge, away from the rising active edge.
module tb_data_sram_axi_bridge;

   logic        clk;
   logic        rst;
   logic        longest_stall;
   logic        data_en;
   logic        data_wen;
   logic [3:0]  data_sel;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [31:0] data_rdata;
   logic        d_stall;
   logic [31:0] araddr;
   logic [2:0]  arsize;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic        rvalid;
   logic        rready;
   logic [31:0] awaddr;
   logic [2:0]  awsize;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic        bvalid;
   logic        bready;

   int tests;
   int fails;

   data_sram_axi_bridge dut (
      .clk          (clk),
      .rst          (rst),
      .longest_stall(longest_stall),
      .data_en      (data_en),
      .data_wen     (data_wen),
      .data_sel     (data_sel),
      .data_addr    (data_addr),
      .data_wdata   (data_wdata),
      .data_rdata   (data_rdata),
      .d_stall      (d_stall),
      .araddr       (araddr),
      .arsize       (arsize),
      .arvalid      (arvalid),
      .arready      (arready),
      .rdata        (rdata),
      .rvalid       (rvalid),
      .rready       (rready),
      .awaddr       (awaddr),
      .awsize       (awsize),
      .awvalid      (awvalid),
      .awready      (awready),
      .wdata        (wdata),
      .wstrb        (wstrb),
      .wvalid       (wvalid),
      .wready       (wready),
      .bvalid       (bvalid),
      .bready       (bready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // Lets done_q clear and idles the request lines between scenarios.
   task automatic release_core();
      data_en       = 1'b0;
      longest_stall = 1'b0;
      step();
      longest_stall = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; longest_stall = 1'b1; data_en = 1'b0; data_wen = 1'b0;
      data_sel = 4'h0; data_addr = '0; data_wdata = '0;
      arready = 1'b0; rvalid = 1'b0; rdata = '0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
      step(); step();
      tests++;
      if ({arvalid, rready, awvalid, wvalid, bready} !== 5'b0) begin
         fails++;
         $display("FAIL reset_valids: got %b, expected 00000",
                  {arvalid, rready, awvalid, wvalid, bready});
      end
      tests++;
      if (data_rdata !== 32'h0 || awaddr !== 32'h0 || araddr !== 32'h0 || wdata !== 32'h0 ||
          wstrb !== 4'h0 || awsize !== 3'd0 || arsize !== 3'd0) begin
         fails++;
         $display("FAIL reset_payload: rdata=%h awaddr=%h araddr=%h wdata=%h wstrb=%h, expected 0",
                  data_rdata, awaddr, araddr, wdata, wstrb);
      end
      data_en = 1'b1;
      #1;
      tests++;
      if (d_stall !== 1'b1) begin
         fails++;
         $display("FAIL reset_dstall_follows_en: got %b, expected 1", d_stall);
      end
      data_en = 1'b0;
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic test_load();
      data_en = 1'b1; data_wen = 1'b0; data_sel = 4'hF; data_addr = 32'h8000_0004;
      #1;
      tests++;
      if (d_stall !== 1'b1 || arvalid !== 1'b0) begin
         fails++;
         $display("FAIL load_c0: d_stall=%b arvalid=%b, expected 1 0", d_stall, arvalid);
      end
      step();
      tests++;
      if (arvalid !== 1'b1 || araddr !== 32'h8000_0004 || arsize !== 3'd2 || d_stall !== 1'b1) begin
         fails++;
         $display("FAIL load_c1_ar: arvalid=%b araddr=%h arsize=%0d d_stall=%b, expected 1 80000004 2 1",
                  arvalid, araddr, arsize, d_stall);
      end
      arready = 1'b1;
      step();
      arready = 1'b0;
      tests++;
      if (arvalid !== 1'b0 || rready !== 1'b1 || d_stall !== 1'b1) begin
         fails++;
         $display("FAIL load_c2_r: arvalid=%b rready=%b d_stall=%b, expected 0 1 1",
                  arvalid, rready, d_stall);
      end
      rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
      step();
      rvalid = 1'b0; rdata = '0;
      tests++;
      if (d_stall !== 1'b0 || data_rdata !== 32'hDEAD_BEEF || rready !== 1'b0) begin
         fails++;
         $display("FAIL load_c3_done: d_stall=%b rdata=%h rready=%b, expected 0 deadbeef 0",
                  d_stall, data_rdata, rready);
      end
      release_core();
   endtask

   task automatic test_store_skewed();
      data_en = 1'b1; data_wen = 1'b1; data_sel = 4'b1100;
      data_addr = 32'h8000_0012; data_wdata = 32'hAABB_0000;
      step();
      tests++;
      if (awvalid !== 1'b1 || wvalid !== 1'b1 || awaddr !== 32'h8000_0012 || awsize !== 3'd1 ||
          wstrb !== 4'b1100 || wdata !== 32'hAABB_0000) begin
         fails++;
         $display("FAIL store_aw_w: awv=%b wv=%b awaddr=%h awsize=%0d wstrb=%b wdata=%h",
                  awvalid, wvalid, awaddr, awsize, wstrb, wdata);
      end
      wready = 1'b1;
      step();
      wready = 1'b0;
      tests++;
      if (wvalid !== 1'b0 || awvalid !== 1'b1) begin
         fails++;
         $display("FAIL store_w_dropped: wvalid=%b awvalid=%b, expected 0 1", wvalid, awvalid);
      end
      for (int i = 0; i < 2; i++) begin
         step();
         tests++;
         if (awvalid !== 1'b1 || wvalid !== 1'b0 || bready !== 1'b0 || d_stall !== 1'b1) begin
            fails++;
            $display("FAIL store_aw_hold%0d: awv=%b wv=%b bready=%b d_stall=%b, expected 1 0 0 1",
                     i, awvalid, wvalid, bready, d_stall);
         end
      end
      awready = 1'b1;
      step();
      awready = 1'b0;
      tests++;
      if (awvalid !== 1'b0 || bready !== 1'b1 || d_stall !== 1'b1) begin
         fails++;
         $display("FAIL store_b: awvalid=%b bready=%b d_stall=%b, expected 0 1 1",
                  awvalid, bready, d_stall);
      end
      bvalid = 1'b1;
      step();
      bvalid = 1'b0;
      tests++;
      if (d_stall !== 1'b0 || bready !== 1'b0 || data_rdata !== 32'hDEAD_BEEF) begin
         fails++;
         $display("FAIL store_done: d_stall=%b bready=%b rdata=%h, expected 0 0 deadbeef",
                  d_stall, bready, data_rdata);
      end
      release_core();
   endtask

   task automatic test_byte_store();
      data_en = 1'b1; data_wen = 1'b1; data_sel = 4'b0010;
      data_addr = 32'h8000_0001; data_wdata = 32'h0000_5A00;
      awready = 1'b1; wready = 1'b1;
      step();
      tests++;
      if (awvalid !== 1'b1 || wvalid !== 1'b1 || awsize !== 3'd0 || wstrb !== 4'b0010) begin
         fails++;
         $display("FAIL byte_store_aw: awv=%b wv=%b awsize=%0d wstrb=%b, expected 1 1 0 0010",
                  awvalid, wvalid, awsize, wstrb);
      end
      step();
      awready = 1'b0; wready = 1'b0;
      bvalid = 1'b1;
      tests++;
      if (bready !== 1'b1 || awvalid !== 1'b0 || wvalid !== 1'b0) begin
         fails++;
         $display("FAIL byte_store_b: bready=%b awv=%b wv=%b, expected 1 0 0", bready, awvalid, wvalid);
      end
      step();
      bvalid = 1'b0;
      tests++;
      if (d_stall !== 1'b0) begin
         fails++;
         $display("FAIL byte_store_done: d_stall=%b, expected 0", d_stall);
      end
      release_core();
   endtask

   task automatic test_stall_hold();
      data_en = 1'b1; data_wen = 1'b0; data_addr = 32'h8000_0008;
      arready = 1'b1; rvalid = 1'b1; rdata = 32'h1234_5678;
      step(); step();
      arready = 1'b0;
      step();
      rvalid = 1'b0; rdata = '0;
      for (int i = 0; i < 5; i++) begin
         tests++;
         if (arvalid !== 1'b0 || d_stall !== 1'b0 || data_rdata !== 32'h1234_5678) begin
            fails++;
            $display("FAIL stall_hold%0d: arvalid=%b d_stall=%b rdata=%h, expected 0 0 12345678",
                     i, arvalid, d_stall, data_rdata);
         end
         step();
      end
      release_core();
   endtask

   task automatic test_orphan_then_reset();
      data_en = 1'b1; data_wen = 1'b0; data_addr = 32'h8000_0010;
      step();
      arready = 1'b1;
      step();
      arready = 1'b0;
      data_en = 1'b0;
      #1;
      tests++;
      if (rready !== 1'b1 || d_stall !== 1'b1) begin
         fails++;
         $display("FAIL orphan_rd_d: rready=%b d_stall=%b, expected 1 1", rready, d_stall);
      end
      step();
      rvalid = 1'b1; rdata = 32'hCAFE_F00D;
      step();
      rvalid = 1'b0; rdata = '0;
      tests++;
      if (data_rdata !== 32'hCAFE_F00D || d_stall !== 1'b0 || rready !== 1'b0) begin
         fails++;
         $display("FAIL orphan_r_accepted: rdata=%h d_stall=%b rready=%b, expected cafef00d 0 0",
                  data_rdata, d_stall, rready);
      end
      // Pipeline stays frozen: a stray done_q would now block this store forever.
      data_en = 1'b1; data_wen = 1'b1; data_sel = 4'hF;
      data_addr = 32'h8000_0020; data_wdata = 32'h0102_0304;
      step();
      tests++;
      if (awvalid !== 1'b1 || wvalid !== 1'b1 || awsize !== 3'd2 || wstrb !== 4'hF) begin
         fails++;
         $display("FAIL orphan_next_store: awv=%b wv=%b awsize=%0d wstrb=%h, expected 1 1 2 f",
                  awvalid, wvalid, awsize, wstrb);
      end
      rst = 1'b1;
      data_en = 1'b0;
      step();
      tests++;
      if ({arvalid, rready, awvalid, wvalid, bready} !== 5'b0 || d_stall !== 1'b0 ||
          data_rdata !== 32'h0 || awaddr !== 32'h0) begin
         fails++;
         $display("FAIL mid_reset: valids=%b d_stall=%b rdata=%h awaddr=%h, expected 00000 0 0 0",
                  {arvalid, rready, awvalid, wvalid, bready}, d_stall, data_rdata, awaddr);
      end
      rst = 1'b0;
      step();
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_load();
      test_store_skewed();
      test_byte_store();
      test_stall_hold();
      test_orphan_then_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
